// File: rtl/me_core_param.sv
// Full-search block motion estimator: N_CH candidate x positions per beat,
// N_Y candidate y positions per block, minimum-SAD winner with its vector.
module me_core_param #(
  parameter  int N_CH     = 16,
  parameter  int N_Y      = 16,
  parameter  int BLK_ROWS = 8,
  parameter  int BLK_COLS = 8,
  parameter  int PIX_W    = 8,
  localparam int SAD_W    = PIX_W + $clog2(BLK_ROWS * BLK_COLS),
  localparam int XW       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int YW       = (N_Y > 1) ? $clog2(N_Y) : 1,
  localparam int RW       = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1,
  localparam int ROW_W    = N_CH * BLK_COLS * PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic [ROW_W-1:0] crt_row,
  input  logic [ROW_W-1:0] pre_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] sad_min,
  output logic [XW-1:0]    mv_x,
  output logic [YW-1:0]    mv_y
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d;

  logic [RW-1:0] row_cnt, eff_row;
  logic [YW-1:0] y_cnt, eff_y;
  logic          accept, restart, last_row, last_beat;

  // Stage 0: per-channel row SADs of the accepted beat
  logic [SAD_W-1:0] row_sad_d [N_CH];
  logic [SAD_W-1:0] row_sad_q [N_CH];
  logic             s0_valid, s0_load, s0_last_row, s0_final;
  logic [YW-1:0]    s0_y;

  // Stage 1: accumulators; s1_valid marks a completed candidate
  logic [SAD_W-1:0] acc_q [N_CH];
  logic             s1_valid, s1_final;
  logic [YW-1:0]    s1_y;

  logic [SAD_W-1:0] cand_min;
  logic [XW-1:0]    cand_idx;
  logic [PIX_W-1:0] pix_a, pix_b;

  assign accept    = in_valid & ready_q;
  // Any beat taken in IDLE, or flagged first in ACC, starts a fresh block.
  assign restart   = (state_q == IDLE) | in_first;
  assign eff_row   = restart ? '0 : row_cnt;
  assign eff_y     = restart ? '0 : y_cnt;
  assign last_row  = (eff_row == RW'(BLK_ROWS - 1));
  assign last_beat = last_row & (eff_y == YW'(N_Y - 1));

  assign in_ready  = ready_q;
  assign out_valid = (state_q == OUT);

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // written variable a default first, so no latch can be inferred.
    pix_a = '0;
    pix_b = '0;
    for (int c = 0; c < N_CH; c++) begin
      row_sad_d[c] = '0;
      for (int k = 0; k < BLK_COLS; k++) begin
        pix_a = crt_row[(c*BLK_COLS+k)*PIX_W +: PIX_W];
        pix_b = pre_row[(c*BLK_COLS+k)*PIX_W +: PIX_W];
        row_sad_d[c] = row_sad_d[c] + SAD_W'((pix_a > pix_b) ? pix_a - pix_b : pix_b - pix_a);
      end
    end
  end

  // Strict less-than keeps the lowest channel index on ties.
  always_comb begin
    cand_min = acc_q[0];
    cand_idx = '0;
    for (int c = 1; c < N_CH; c++) begin
      if (acc_q[c] < cand_min) begin
        cand_min = acc_q[c];
        cand_idx = XW'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: begin
        ready_d = ~(accept & last_beat);
        if (accept) state_d = ACC;
      end
      ACC: begin
        ready_d = ready_q & ~(accept & last_beat);
        if (s1_valid && s1_final) state_d = OUT;
      end
      OUT: begin
        ready_d = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      y_cnt       <= '0;
      s0_valid    <= 1'b0;
      s0_load     <= 1'b0;
      s0_last_row <= 1'b0;
      s0_final    <= 1'b0;
      s0_y        <= '0;
      s1_valid    <= 1'b0;
      s1_final    <= 1'b0;
      s1_y        <= '0;
      sad_min     <= '1;
      mv_x        <= '0;
      mv_y        <= '0;
      // NOTE: the row-SAD and accumulator arrays are reset as well, so no
      // partial block can ever leak into a result after reset.
      for (int c = 0; c < N_CH; c++) begin
        row_sad_q[c] <= '0;
        acc_q[c]     <= '0;
      end
    end else begin
      s0_valid <= accept;
      if (accept) begin
        for (int c = 0; c < N_CH; c++) row_sad_q[c] <= row_sad_d[c];
        s0_load     <= (eff_row == '0);
        s0_last_row <= last_row;
        s0_final    <= last_beat;
        s0_y        <= eff_y;
        if (last_beat) begin
          row_cnt <= '0;
          y_cnt   <= '0;
        end else if (last_row) begin
          row_cnt <= '0;
          y_cnt   <= eff_y + 1'b1;
        end else begin
          row_cnt <= eff_row + 1'b1;
          y_cnt   <= eff_y;
        end
      end

      s1_valid <= s0_valid & s0_last_row;
      if (s0_valid) begin
        for (int c = 0; c < N_CH; c++)
          acc_q[c] <= s0_load ? row_sad_q[c] : acc_q[c] + row_sad_q[c];
        s1_final <= s0_final;
        s1_y     <= s0_y;
      end

      // Candidate y=0 reloads unconditionally, discarding any earlier block.
      if (s1_valid && ((s1_y == '0) || (cand_min < sad_min))) begin
        sad_min <= cand_min;
        mv_x    <= cand_idx;
        mv_y    <= s1_y;
      end
    end
  end

endmodule

// File: tb/tb_me_core_param.sv
// Directed bench for me_core_param: pattern blocks with hand-computed
// winners, back-pressure, abort via in_first and mid-block reset.
module tb_me_core_param;
  localparam int N_CH = 16, N_Y = 16, BLK_ROWS = 8, BLK_COLS = 8, PIX_W = 8;
  localparam int SAD_W = 14, XW = 4, YW = 4;
  localparam int ROW_W = N_CH * BLK_COLS * PIX_W;
  localparam int BEATS = N_Y * BLK_ROWS;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_first, out_valid, out_ready;
  logic [ROW_W-1:0] crt_row, pre_row;
  logic [SAD_W-1:0] sad_min;
  logic [XW-1:0]    mv_x;
  logic [YW-1:0]    mv_y;

  int checks = 0, failures = 0;
  int n_hs = 0, exp_hs = 0;
  int cval, pval, nz, gap_pct;
  int zx [4];
  int zy [4];

  me_core_param #(.N_CH(N_CH), .N_Y(N_Y), .BLK_ROWS(BLK_ROWS), .BLK_COLS(BLK_COLS),
                  .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .crt_row(crt_row), .pre_row(pre_row), .out_valid(out_valid), .out_ready(out_ready),
    .sad_min(sad_min), .mv_x(mv_x), .mv_y(mv_y));

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid === 1'b1 && out_ready === 1'b1) n_hs <= n_hs + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic set_pattern(input int cv, input int pv);
    cval = cv;
    pval = pv;
    nz   = 0;
  endtask

  task automatic add_zero(input int x, input int y);
    zx[nz] = x;
    zy[nz] = y;
    nz++;
  endtask

  task automatic build_row(input int y);
    logic [PIX_W-1:0] cv8, pv8;
    bit hit;
    cv8 = PIX_W'(cval);
    pv8 = PIX_W'(pval);
    for (int c = 0; c < N_CH; c++) begin
      hit = 1'b0;
      for (int i = 0; i < nz; i++) if (zx[i] == c && zy[i] == y) hit = 1'b1;
      for (int k = 0; k < BLK_COLS; k++) begin
        crt_row[(c*BLK_COLS+k)*PIX_W +: PIX_W] = cv8;
        pre_row[(c*BLK_COLS+k)*PIX_W +: PIX_W] = hit ? cv8 : pv8;
      end
    end
  endtask

  // Drives beats lo..hi of a block; returns right after the accepting edge of the last one.
  task automatic send_beats(input int lo, input int hi, input bit first_at_lo);
    int n;
    for (int b = lo; b <= hi; b++) begin
      @(negedge clk);
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_first = 1'b0;
        @(negedge clk);
      end
      build_row(b / BLK_ROWS);
      in_valid = 1'b1;
      in_first = first_at_lo && (b == lo);
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("beat_accept", in_ready, 1);
      @(posedge clk);
    end
  endtask

  task automatic wait_result(input string tag, input int e_sad, input int e_x, input int e_y,
                             input int hold);
    int cnt;
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check({tag, "_ready_drained"}, in_ready, 0);
    end while (out_valid !== 1'b1 && cnt < 60);
    check({tag, "_latency"}, cnt, 3);
    check({tag, "_sad"}, sad_min, e_sad);
    check({tag, "_mvx"}, mv_x, e_x);
    check({tag, "_mvy"}, mv_y, e_y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_sad"}, sad_min, e_sad);
      check({tag, "_hold_mvx"}, mv_x, e_x);
      check({tag, "_hold_mvy"}, mv_y, e_y);
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(posedge clk);
    exp_hs++;
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
    check({tag, "_result_count"}, n_hs, exp_hs);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    crt_row   = '0;
    pre_row   = '0;
    gap_pct   = 0;
    set_pattern(0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sad_min", sad_min, 32'h3fff);
    check("rst_mvx", mv_x, 0);
    check("rst_mvy", mv_y, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // Unique zero at (5,3); every other candidate SAD is 64
    set_pattern(100, 101);
    add_zero(5, 3);
    send_beats(0, BEATS - 1, 1'b1);
    wait_result("single", 0, 5, 3, 0);

    // Identical frames: all tie at zero, (0,0) wins
    set_pattern(77, 77);
    send_beats(0, BEATS - 1, 1'b0);
    wait_result("all_tie", 0, 0, 0, 0);

    // Worst case 64*255 without overflow
    set_pattern(255, 0);
    send_beats(0, BEATS - 1, 1'b1);
    wait_result("worst", 16320, 0, 0, 0);

    // Ties inside (3,7 at y=4) and across y (1 at y=6), under back-pressure
    set_pattern(50, 60);
    add_zero(7, 4);
    add_zero(3, 4);
    add_zero(1, 6);
    out_ready = 1'b0;
    send_beats(0, BEATS - 1, 1'b1);
    wait_result("hold", 0, 3, 4, 10);

    // Block A aborted at beat 50 by block B (zero at 2,9)
    set_pattern(77, 77);
    send_beats(0, 49, 1'b1);
    set_pattern(100, 101);
    add_zero(2, 9);
    send_beats(0, BEATS - 1, 1'b1);
    wait_result("abort", 0, 2, 9, 0);

    // Reset at beat 70 with random gaps, then a fresh gapped block
    gap_pct = 30;
    set_pattern(100, 101);
    add_zero(0, 0);
    send_beats(0, 69, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sad_min", sad_min, 32'h3fff);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_stale", out_valid, 0);
    check("midrst_count", n_hs, exp_hs);
    set_pattern(100, 101);
    add_zero(5, 3);
    send_beats(0, BEATS - 1, 1'b1);
    wait_result("after_rst", 0, 5, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
